// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline definitions: bubble encoding, default boot address
// and the instruction-fetch state encoding.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // FETCH: idle, ready to issue
    // WAIT : one request outstanding
    // KILL : outstanding response must be dropped (redirected)
    // HOLD : word fetched while stalled, parked in hold_instr
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        KILL  = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_fetch.sv
// MIPS32 instruction-fetch stage. Owns the PC, keeps one request in flight
// to instruction memory, buffers a word across downstream stalls and applies
// ID-stage redirects, dropping any response that belongs to the old stream.
module if_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_o,
    output logic [31:0] pc_current_o,
    output logic [31:0] pc4_o
);

    fetch_state_t state;
    logic [31:0]  fetch_pc;
    logic [31:0]  req_pc;
    logic [31:0]  hold_instr;

    logic         issue;
    logic         deliver;
    logic [31:0]  deliver_word;
    logic [31:0]  target;

    assign target = {redirect_pc[31:2], 2'b00};

    // Decide this cycle's issue/deliver; redirect suppresses both everywhere.
    always_comb begin
        issue        = 1'b0;
        deliver      = 1'b0;
        deliver_word = hold_instr;
        if (!redirect) begin
            unique case (state)
                FETCH: issue = !stall;
                WAIT: begin
                    if (imem_rvalid && !stall) begin
                        deliver      = 1'b1;
                        deliver_word = imem_rdata;
                        issue        = 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        deliver = 1'b1;
                        issue   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The request pulse is combinational so the first fetch goes out in the
    // first cycle after reset; gate it so nothing is issued while in reset.
    assign imem_req  = issue & ~reset;
    assign imem_addr = fetch_pc;

    // Fetch FSM, PC and hold buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            fetch_pc   <= RESET_PC;
            req_pc     <= RESET_PC;
            hold_instr <= NOP_INSTR;
        end else begin
            if (redirect)
                fetch_pc <= target;
            else if (issue)
                fetch_pc <= fetch_pc + 32'd4;

            if (issue)
                req_pc <= fetch_pc;

            unique case (state)
                FETCH: begin
                    // Responses seen here are stale (pre-reset) and ignored.
                    if (issue)
                        state <= WAIT;
                end
                WAIT: begin
                    if (redirect)
                        state <= imem_rvalid ? FETCH : KILL;
                    else if (imem_rvalid && stall) begin
                        hold_instr <= imem_rdata;
                        state      <= HOLD;
                    end
                end
                KILL: begin
                    if (imem_rvalid)
                        state <= FETCH;
                end
                HOLD: begin
                    if (redirect) begin
                        hold_instr <= NOP_INSTR;
                        state      <= FETCH;
                    end else if (!stall)
                        state <= WAIT;
                end
                default: state <= FETCH;
            endcase
        end
    end

    // IF/ID outputs: redirect bubble, then delivery, then stall hold, else bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_o      <= NOP_INSTR;
            pc_current_o <= 32'h0;
            pc4_o        <= 32'h0;
        end else if (redirect) begin
            instr_o      <= NOP_INSTR;
            pc_current_o <= 32'h0;
            pc4_o        <= 32'h0;
        end else if (deliver) begin
            instr_o      <= deliver_word;
            pc_current_o <= req_pc;
            pc4_o        <= req_pc + 32'd4;
        end else if (!stall) begin
            instr_o      <= NOP_INSTR;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch: a variable-latency memory model drives the
// fetch port, a program-order stream model feeds an expectation queue, and a
// monitor checks every output update against it.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_o;
    logic [31:0] pc_current_o;
    logic [31:0] pc4_o;

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instr_o      (instr_o),
        .pc_current_o (pc_current_o),
        .pc4_o        (pc4_o)
    );

    always #5 clk = ~clk;

    // Expected delivery stream; a mark entry separates streams at a redirect.
    typedef struct {
        bit          mark;
        logic [31:0] pc;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp   = 0;
    int n_bad   = 0;
    int n_deliv = 0;

    // Stimulus knobs.
    int          lat_fixed = 1;    // 0: random 1..4
    int          stall_p   = 0;
    int          redir_p   = 0;
    int          rvred_p   = 0;    // chance of redirect+stall on a response
    bit          force_red = 0;
    logic [31:0] force_pc  = 32'h0;

    // Memory model state.
    bit          outst = 0;
    int          cnt   = 0;
    logic [31:0] oaddr = 32'h0;
    logic [31:0] stream_pc = 32'h0;

    // Memory contents: nonzero for every aligned address, encodes the address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0003;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fill_q();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{mark: 1'b0, pc: stream_pc});
            stream_pc = stream_pc + 32'd4;
        end
    endtask

    // One clock cycle of stimulus plus the memory side of the handshake.
    task automatic step();
        bit          rv;
        bit          red;
        logic [31:0] tgt;
        @(posedge clk);
        #1;
        rv = 1'b0;
        if (outst) begin
            cnt--;
            if (cnt == 0) begin
                rv    = 1'b1;
                outst = 1'b0;
            end
        end
        imem_rvalid = rv;
        imem_rdata  = rv ? word_of(oaddr) : $urandom;

        stall = ($urandom_range(99) < stall_p);
        red   = force_red || ($urandom_range(99) < redir_p);
        if (rv && ($urandom_range(99) < rvred_p)) begin
            red   = 1'b1;
            stall = 1'b1;
        end
        if (force_red)
            tgt = force_pc;
        else if ($urandom_range(9) == 0)
            tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        else
            tgt = $urandom & 32'h0000_0FFF;
        redirect    = red;
        redirect_pc = red ? tgt : $urandom;
        if (red) begin
            exp_q.push_back('{mark: 1'b1, pc: 32'h0});
            stream_pc = {tgt[31:2], 2'b00};
        end
        force_red = 1'b0;
        fill_q();

        #1;
        if (imem_req) begin
            chk("one_outstanding", {31'b0, outst}, 32'h0);
            chk("addr_aligned", {30'b0, imem_addr[1:0]}, 32'h0);
            outst = 1'b1;
            oaddr = imem_addr;
            cnt   = (lat_fixed != 0) ? lat_fixed : $urandom_range(1, 4);
        end
    endtask

    // Monitor: inputs sampled at the edge, outputs checked at the next negedge.
    logic [31:0] p_instr = 32'h0, p_pc = 32'h0, p_pc4 = 32'h0;
    always begin
        bit e_stall, e_red, e_rst, found;
        exp_t h;
        @(posedge clk);
        e_stall = stall;
        e_red   = redirect;
        e_rst   = reset;
        @(negedge clk);
        if (!e_rst) begin
            if (e_red) begin
                chk("redirect_bubble_instr", instr_o, 32'h0);
                chk("redirect_bubble_pc", pc_current_o, 32'h0);
                chk("redirect_bubble_pc4", pc4_o, 32'h0);
                found = 1'b0;
                while (!found && exp_q.size() > 0) begin
                    h = exp_q.pop_front();
                    found = h.mark;
                end
                chk("redirect_marker", {31'b0, found}, 32'h1);
            end else if (e_stall) begin
                chk("stall_hold_instr", instr_o, p_instr);
                chk("stall_hold_pc", pc_current_o, p_pc);
                chk("stall_hold_pc4", pc4_o, p_pc4);
            end else if (instr_o != 32'h0) begin
                n_deliv++;
                if (exp_q.size() == 0 || exp_q[0].mark) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_delivery: got pc %h instr %h, nothing expected at %0t",
                             pc_current_o, instr_o, $time);
                end else begin
                    h = exp_q.pop_front();
                    chk("deliver_pc", pc_current_o, h.pc);
                    chk("deliver_instr", instr_o, word_of(h.pc));
                    chk("deliver_pc4", pc4_o, h.pc + 32'd4);
                end
            end else begin
                chk("bubble_pc_hold", pc_current_o, p_pc);
                chk("bubble_pc4_hold", pc4_o, p_pc4);
            end
        end
        p_instr = instr_o;
        p_pc    = pc_current_o;
        p_pc4   = pc4_o;
    end

    initial begin
        int d0;
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        stream_pc   = 32'h0;
        fill_q();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_imem_req", {31'b0, imem_req}, 32'h0);
        chk("reset_instr", instr_o, 32'h0);
        chk("reset_pc", pc_current_o, 32'h0);
        chk("reset_pc4", pc4_o, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("first_req", {31'b0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0);
        outst = 1'b1;
        oaddr = imem_addr;
        cnt   = 1;

        // 1-cycle memory: one instruction per cycle in steady state.
        lat_fixed = 1;
        repeat (5) step();
        d0 = n_deliv;
        repeat (20) step();
        chk("throughput_lat1", n_deliv - d0, 20);

        // Stall for 4 cycles, then release.
        stall_p = 100;
        repeat (4) step();
        stall_p = 0;
        repeat (6) step();

        // 3-cycle memory: one instruction every 3 cycles.
        lat_fixed = 3;
        repeat (6) step();
        d0 = n_deliv;
        repeat (30) step();
        chk("throughput_lat3", n_deliv - d0, 10);

        // Redirect to 0x400 with a request in flight.
        force_red = 1'b1;
        force_pc  = 32'h0000_0401;
        repeat (12) step();

        // Wrap: word at 0xFFFF_FFFC has pc4 = 0, next fetch is 0.
        lat_fixed = 1;
        force_red = 1'b1;
        force_pc  = 32'hFFFF_FFFE;
        repeat (10) step();

        // Redirect coinciding with a response under stall.
        lat_fixed = 2;
        rvred_p   = 50;
        repeat (60) step();
        rvred_p   = 0;

        // Mixed random traffic.
        lat_fixed = 0;
        stall_p   = 30;
        redir_p   = 4;
        rvred_p   = 5;
        repeat (3000) step();
        stall_p = 0;
        redir_p = 0;
        rvred_p = 0;
        repeat (10) step();

        chk("progress", {31'b0, (n_deliv >= 500)}, 32'h1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
